// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory arbiter sharing one memory between fetch (IF) and data (D) requesters.
// D has priority; defining ARB_FAIRNESS_EN adds a starvation guard that bounds how long IF can wait.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
        $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be in 1..15");
    end

    state_t     r_state;
    logic       r_own_d;
    logic [3:0] r_wcnt;
    logic       w_arb, w_pick_d, w_pick_if, w_win, w_to_resp;

    assign w_arb = (r_state == IDLE) || (r_state == RESP);

`ifdef ARB_FAIRNESS_EN
    logic [3:0] r_starve;
    // once D has won STARVE_MAX times in a row over a waiting fetch, IF takes the next slot
    assign w_pick_d = d_req && !(if_req && r_starve == 4'(STARVE_MAX));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_starve <= '0;
        else if (w_arb)
            r_starve <= (!if_req || !w_pick_d) ? '0 :
                        (r_starve == 4'(STARVE_MAX)) ? r_starve : r_starve + 4'd1;
`else
    assign w_pick_d = d_req;
`endif

    assign w_pick_if = if_req && !w_pick_d;
    assign w_win     = w_arb && (w_pick_d || w_pick_if);
    assign w_to_resp = (r_state == ISSUE && MEM_LAT == 1) ||
                       (r_state == WAIT && r_wcnt == 4'(MEM_LAT - 2));
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign busy      = r_state != IDLE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state   <= IDLE;
            r_own_d   <= 1'b0;
            r_wcnt    <= '0;
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_gnt    <= w_arb && w_pick_if;
            d_gnt     <= w_arb && w_pick_d;
            mem_en    <= w_win;
            if_rvalid <= w_to_resp && !r_own_d;
            d_rvalid  <= w_to_resp && r_own_d;
            if (w_win) begin
                r_state  <= ISSUE;
                r_own_d  <= w_pick_d;
                mem_addr <= w_pick_d ? d_addr : if_addr;
                mem_we   <= w_pick_d && d_we;
                if (w_pick_d)
                    mem_wdata <= d_wdata;
            end else if (w_arb) begin
                r_state <= IDLE;
            end else if (r_state == ISSUE) begin
                r_state <= (MEM_LAT == 1) ? RESP : WAIT;
                r_wcnt  <= '0;
            end else begin
                r_state <= w_to_resp ? RESP : WAIT;
                r_wcnt  <= (r_wcnt == 4'hF) ? r_wcnt : r_wcnt + 4'd1;
            end
        end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the fetch stage (IF requester) and the memory stage (D requester) of the 5-stage pipeline. It owns the memory control pins, serialises accesses and issues one transaction at a time. It returns read data and completion strobes to the requester that owns the transaction. Data requests have priority over fetch; an optional starvation guard bounds fetch wait time.

## Interface
Parameters:
- AW, 32: address width.
- DW, 32: data width.
- MEM_LAT, 2: cycles from the mem_en cycle to the cycle in which mem_rdata is valid. Legal values are 1–15.
- STARVE_MAX, 4: consecutive D grants allowed while if_req is pending. Used only when ARB_FAIRNESS_EN is defined. Legal values are 1–15.

Ports:
- clk  in  1  Single clock. All state updates on posedge.
- rst_n  in  1  Reset, asynchronous, active-low.
- if_req  in  1  Fetch read request. Held high until if_gnt.
- if_addr  in  AW  Fetch address. Stable while if_req is high.
- if_gnt  out  1  One-cycle pulse: fetch request accepted.
- if_rvalid  out  1  One-cycle pulse: if_rdata valid.
- if_rdata  out  DW  Fetch read data. Equals mem_rdata.
- d_req  in  1  Data request. Held high until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  Data address.
- d_wdata  in  DW  Write data.
- d_gnt  out  1  One-cycle pulse: data request accepted.
- d_rvalid  out  1  One-cycle pulse: read data valid, or write complete.
- d_rdata  out  DW  Data read data. Equals mem_rdata.
- mem_en  out  1  Memory access strobe. High for exactly one cycle per transaction.
- mem_we  out  1  Memory write enable. Qualified by mem_en.
- mem_addr  out  AW  Memory address. Registered, held for the whole transaction.
- mem_wdata  out  DW  Memory write data. Registered.
- mem_rdata  in  DW  Memory read data.
- busy  out  1  High whenever state ≠ IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **Arbitration** is evaluated in IDLE and in RESP.
  - If d_req=1, D wins; otherwise, if if_req=1, IF wins.
  - On the edge after a win, the arbiter latches the owner, addr, we (0 for IF) and wdata, then enters ISSUE.
- **ISSUE** (1 cycle): owner's gnt=1, mem_en=1. Next state is WAIT if MEM_LAT>1, otherwise RESP.
- **WAIT:** a 4-bit counter runs MEM_LAT-1 cycles, then the block enters RESP.
- **RESP** (1 cycle): owner's rvalid=1; the owner's rdata is valid this cycle.
  - Next state is ISSUE if a request is pending, otherwise IDLE.
- **Writes:** complete with d_rvalid. d_rdata is don't-care for writes.
- **Withdrawal:** a requester that drops req before its gnt pulse withdraws cleanly. No transaction is issued for it.
- The non-owner's gnt and rvalid stay 0 for the entire transaction.
- **Memory pins:** mem_addr, mem_we and mem_wdata are held at the latched values from ISSUE through RESP. They hold their last values in IDLE. mem_we is only meaningful while mem_en=1.

## Timing
- Request at cycle 0 (in IDLE): gnt and mem_en in cycle 1; rvalid in cycle 1+MEM_LAT.
- Back-to-back issue period is 1+MEM_LAT cycles. A new ISSUE immediately follows RESP, with no idle bubble.
- Simultaneous if_req and d_req: D is granted first. IF is granted in the ISSUE that follows D's RESP, unless a new d_req is pending. See Configuration.
- **Reset values:** all gnt, rvalid and mem_en = 0; mem_we = 0; mem_addr and mem_wdata = 0; busy = 0; state IDLE; counters 0.
- **Reset mid-transaction:** the transaction is aborted immediately. No rvalid is emitted, and the memory result is discarded.
- **Arithmetic:**
  - The WAIT counter is 4 bits wide and saturates; it does not wrap.
  - The starvation counter is 4 bits wide and saturates at STARVE_MAX.

## Configuration
- **ARB_FAIRNESS_EN defined:** the starvation guard is enabled.
  - The counter increments on each D grant made while if_req=1.
  - It clears on an IF grant, or in any arbitration cycle where if_req=0.
  - When the counter equals STARVE_MAX, the next arbitration grants IF even if d_req=1.
- **ARB_FAIRNESS_EN undefined:** strict D priority. The counter logic is absent, and IF can starve indefinitely.

## Test plan
- **Single fetch:** MEM_LAT=2, if_req with if_addr=0x40, memory returns 0xDEADBEEF.
  - if_gnt and mem_en in cycle 1, with mem_addr=0x40 and mem_we=0.
  - if_rvalid in cycle 3 with if_rdata=0xDEADBEEF.
  - busy high in cycles 1–3.
- **Data write:** d_req with d_we=1, d_addr=0x10, d_wdata=0x1234.
  - mem_en=1 and mem_we=1 in cycle 1, with mem_wdata=0x1234.
  - d_rvalid in cycle 3; if_* strobes remain 0 throughout.
- **Contention:** if_req and d_req rise together.
  - D is served first: d_gnt in cycle 1, d_rvalid in cycle 3.
  - IF is served next: if_gnt in cycle 4 (no IDLE cycle), if_rvalid in cycle 6.
- **Starvation guard:** ARB_FAIRNESS_EN defined, STARVE_MAX=4, d_req held high continuously, if_req high.
  - Exactly 4 D grants occur, then an if_gnt.
  - With the macro undefined, if_gnt never asserts over 20 D transactions.
- **Reset mid-transaction:** rst_n asserted low during WAIT of a D read.
  - Outputs go to their reset values asynchronously.
  - No d_rvalid is seen afterwards; after reset is released, the next request is served normally.
- **MEM_LAT=1 and withdrawal:**
  - ISSUE is followed directly by RESP (rvalid in cycle 2).
  - if_req that drops while a D transaction is busy produces no if_gnt and no memory access.
